mul54_seq: RTL and testbench
============================

# mul54_seq

Sequencing controller that computes an unsigned 54x54 -> 108-bit product using the shared combinational 27x27 -> 54-bit `multiplier` in four passes. It accepts an operand pair over a valid/ready handshake, splits each operand into 27-bit halves, and drives the four partial products through the multiplier on consecutive cycles. It accumulates the shifted partial products and presents the result over a second valid/ready handshake. It sits between the mantissa-product stage of the floating-point multiply path and the single `multiplier` instance.

## Interface
- `HALF`, 27: half-operand width. Operands are 2*HALF bits; the product is 4*HALF bits; the multiplier ports are HALF and 2*HALF bits.

- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: controller can accept an operand pair.
- `in_a` in 54: multiplicand, unsigned.
- `in_b` in 54: multiplier operand, unsigned.
- `out_valid` out 1: `out_p` holds a completed product.
- `out_ready` in 1: consumer takes the product.
- `out_p` out 108: product, unsigned.
- `busy` out 1: high in MUL.
- `mul_a` out 27: operand to the shared multiplier's A port.
- `mul_b` out 27: operand to the shared multiplier's B port.
- `mul_p` in 54: product returned by the shared multiplier (combinational, same cycle).

## Operation
- Operand split: `aL = a[26:0]`, `aH = a[53:27]`; `bL` and `bH` are split the same way.
- State machine states: IDLE, MUL, DONE. MUL carries a 2-bit step counter `k`.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid`: latch `in_a`/`in_b`, clear the accumulator, set `k = 0`, go to MUL.
- MUL: drive `mul_a`/`mul_b` combinationally from the latched halves. Each edge does `acc += mul_p << shift`, then `k++`.
  - `k = 0`: aL*bL, shift 0.
  - `k = 1`: aL*bH, shift 27.
  - `k = 2`: aH*bL, shift 27.
  - `k = 3`: aH*bH, shift 54. After this edge the state goes to DONE.
- DONE:
  - `out_valid = 1`; `out_p` equals the accumulator.
  - On `out_ready`: if `in_valid` is also high, latch the new operands and go to MUL; otherwise go to IDLE.
- `in_ready = (state == IDLE) | (state == DONE & out_ready)`. `in_ready` is combinational from `out_ready`; this is the only comb path from input to output.
- `mul_a = mul_b = 0` in IDLE and DONE.
- The accumulator is 108 bits and cannot overflow (max product < 2^108). All arithmetic is unsigned and zero-extended.
- `in_valid` while `in_ready = 0` is ignored. The inputs are not sampled in that case.

## Timing
- Reset (async assert; deassert sampled on `clk`):
  - state IDLE, `k = 0`, accumulator 0.
  - `out_valid = 0`, `out_p = 0`, `busy = 0`.
  - `mul_a = 0`, `mul_b = 0`, `in_ready = 1`.
- Latency: if acceptance happens at edge T0, MUL covers the cycles ending at edges T1..T4. `out_valid` rises after T4, i.e. 4 cycles after acceptance.
- Throughput:
  - With `out_ready` held high and back-to-back `in_valid`: one product per 5 cycles (the DONE cycle doubles as the acceptance cycle).
  - With an idle gap: 6 cycles.
- Backpressure: in DONE with `out_ready = 0`, `out_p` and `out_valid` hold stable indefinitely and `in_ready = 0`.
- Reset mid-operation: any state returns to IDLE immediately and the partial accumulation is discarded. `out_valid` does not assert for the aborted operation.
- `busy` is high exactly during the 4 MUL cycles.

## Test plan
- **Reset:** hold `reset_n` low mid-MUL -> `out_valid = 0`, `out_p = 0`, `in_ready = 1`, `busy = 0`, `mul_a = mul_b = 0`, asynchronously and without a clock edge.
- **Small operands:** `in_a = 3`, `in_b = 5` -> `mul_a`/`mul_b` sequence (3,5), (3,0), (0,5), (0,0). `out_p = 15`, with `out_valid` exactly 4 cycles after acceptance.
- **Cross terms:** `in_a = 2^27`, `in_b = 2^27 + 1` -> `out_p = 2^54 + 2^27`.
- **Max operands:** `in_a = in_b = 2^54 - 1` -> `out_p = 2^108 - 2^55 + 1`, with no accumulator wrap.
- **Backpressure and back-to-back:**
  - `out_ready` low for 3 cycles after `out_valid`, with `in_valid` high and `in_a = 7`, `in_b = 9` -> `out_p` stable and `in_ready = 0`.
  - Then raise `out_ready` -> the next op is accepted in the same cycle and `out_p = 63` follows 4 cycles later.
- **Reset mid-operation:** pulse `reset_n` low at `k = 2` -> no `out_valid`. A subsequent `in_a = 255`, `in_b = 15` -> `out_p = 3825`.

Source files
------------

// File: rtl/mul54_seq.sv
// Sequential 54x54 -> 108-bit unsigned multiplier controller. It issues four 27x27 partial
// products to a shared external multiplier and accumulates them.
module mul54_seq #(
  parameter int unsigned HALF = 27
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*HALF-1:0] in_a,
  input  logic [2*HALF-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*HALF-1:0] out_p,
  output logic              busy,
  output logic [HALF-1:0]   mul_a,
  output logic [HALF-1:0]   mul_b,
  input  logic [2*HALF-1:0] mul_p
);

  localparam int unsigned OW = 2 * HALF;
  localparam int unsigned PW = 4 * HALF;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      k_q, k_d;
  logic [OW-1:0]   a_q, a_d, b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   term;
  logic            load;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    term      = '0;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    mul_a     = '0;
    mul_b     = '0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = StMul;
        end
      end
      StMul: begin
        busy = 1'b1;
        // Cross terms share the same HALF shift; the high term lands at 2*HALF.
        unique case (k_q)
          2'd0: begin
            mul_a = a_q[HALF-1:0];
            mul_b = b_q[HALF-1:0];
            term  = PW'(mul_p);
          end
          2'd1: begin
            mul_a = a_q[HALF-1:0];
            mul_b = b_q[OW-1:HALF];
            term  = PW'(mul_p) << HALF;
          end
          2'd2: begin
            mul_a = a_q[OW-1:HALF];
            mul_b = b_q[HALF-1:0];
            term  = PW'(mul_p) << HALF;
          end
          2'd3: begin
            mul_a = a_q[OW-1:HALF];
            mul_b = b_q[OW-1:HALF];
            term  = PW'(mul_p) << OW;
          end
        endcase
        acc_d = acc_q + term;
        k_d   = k_q + 2'd1;
        if (k_q == 2'd3) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load    = 1'b1;
            state_d = StMul;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      a_d   = in_a;
      b_d   = in_b;
      acc_d = '0;
      k_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      k_q     <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign out_p = acc_q;

endmodule

// File: tb/tb_mul54_seq.sv
// Directed bench for mul54_seq; models the shared 27x27 multiplier combinationally.
module tb_mul54_seq;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [53:0]   in_a, in_b;
  logic          out_valid;
  logic          out_ready;
  logic [107:0]  out_p;
  logic          busy;
  logic [26:0]   mul_a, mul_b;
  logic [53:0]   mul_p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mul_p = {27'b0, mul_a} * {27'b0, mul_b};

  mul54_seq #(.HALF(27)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p)
  );

  task automatic chk(input string tag, input logic [107:0] obs, input logic [107:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair from IDLE, check the issue sequence, then drain the result.
  task automatic run_op(input string tag, input logic [53:0] a, input logic [53:0] b,
                        input logic [107:0] exp);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    #1;
    chk({tag, " in_ready"}, 108'(in_ready), 108'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, " busy"}, 108'(busy), 108'd1);
      chk({tag, " out_valid early"}, 108'(out_valid), 108'd0);
      step();
    end
    chk({tag, " out_valid"}, 108'(out_valid), 108'd1);
    chk({tag, " out_p"}, out_p, exp);
    chk({tag, " busy done"}, 108'(busy), 108'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chk({tag, " idle"}, 108'(out_valid), 108'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    #3;
    chk("rst out_valid", 108'(out_valid), 108'd0);
    chk("rst out_p", out_p, 108'd0);
    chk("rst in_ready", 108'(in_ready), 108'd1);
    chk("rst busy", 108'(busy), 108'd0);
    chk("rst mul_a", 108'(mul_a), 108'd0);
    step();
    reset_n = 1'b1;
    step();

    // Small operands: check the exact multiplier operand sequence.
    in_valid = 1'b1;
    in_a     = 54'd3;
    in_b     = 54'd5;
    step();
    in_valid = 1'b0;
    chk("small k0 a", 108'(mul_a), 108'd3);
    chk("small k0 b", 108'(mul_b), 108'd5);
    step();
    chk("small k1 a", 108'(mul_a), 108'd3);
    chk("small k1 b", 108'(mul_b), 108'd0);
    step();
    chk("small k2 a", 108'(mul_a), 108'd0);
    chk("small k2 b", 108'(mul_b), 108'd5);
    step();
    chk("small k3 a", 108'(mul_a), 108'd0);
    chk("small k3 b", 108'(mul_b), 108'd0);
    chk("small k3 out_valid", 108'(out_valid), 108'd0);
    step();
    chk("small out_valid", 108'(out_valid), 108'd1);
    chk("small out_p", out_p, 108'd15);
    chk("small in_ready bp", 108'(in_ready), 108'd0);
    chk("small mul_a done", 108'(mul_a), 108'd0);
    out_ready = 1'b1;
    #1;
    chk("small in_ready comb", 108'(in_ready), 108'd1);
    step();
    out_ready = 1'b0;
    #1;
    chk("small idle out_valid", 108'(out_valid), 108'd0);

    run_op("cross", 54'd1 << 27, (54'd1 << 27) + 54'd1, (108'd1 << 54) + (108'd1 << 27));
    run_op("max", {54{1'b1}}, {54{1'b1}}, ~108'd0 - (108'd1 << 55) + 108'd2);

    // Backpressure with a pending operand pair, then same-cycle acceptance in DONE.
    in_valid = 1'b1;
    in_a     = 54'd11;
    in_b     = 54'd13;
    step();
    in_a = 54'd7;
    in_b = 54'd9;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 3; i++) begin
      chk("bp out_valid", 108'(out_valid), 108'd1);
      chk("bp out_p", out_p, 108'd143);
      chk("bp in_ready", 108'(in_ready), 108'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("b2b in_ready", 108'(in_ready), 108'd1);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b busy", 108'(busy), 108'd1);
    chk("b2b mul_a", 108'(mul_a), 108'd7);
    chk("b2b mul_b", 108'(mul_b), 108'd9);
    for (int i = 0; i < 4; i++) step();
    chk("b2b out_valid", 108'(out_valid), 108'd1);
    chk("b2b out_p", out_p, 108'd63);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset pulse at k = 2 aborts the operation.
    in_valid = 1'b1;
    in_a     = 54'd1000;
    in_b     = 54'd1000;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("abort pre busy", 108'(busy), 108'd1);
    reset_n = 1'b0;
    #1;
    chk("abort out_valid", 108'(out_valid), 108'd0);
    chk("abort out_p", out_p, 108'd0);
    chk("abort in_ready", 108'(in_ready), 108'd1);
    chk("abort busy", 108'(busy), 108'd0);
    chk("abort mul_a", 108'(mul_a), 108'd0);
    chk("abort mul_b", 108'(mul_b), 108'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("abort no out_valid", 108'(out_valid), 108'd0);
      step();
    end
    run_op("post", 54'd255, 54'd15, 108'd3825);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
